// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit: owns the PC, issues one read per cycle to a 1-cycle synchronous RAM
// and buffers returned words with their PCs in a small prefetch FIFO feeding decode.
module instr_fetch_queue #(
    parameter int unsigned          ADDR_W   = 32,
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          DEPTH    = 4,
    parameter logic [ADDR_W-1:0]    RESET_PC = {ADDR_W{1'b0}},
    parameter int unsigned          PC_STEP  = 4
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic                      fetch_en,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         mem_q,
    input  logic                      redirect_valid,
    input  logic [ADDR_W-1:0]         redirect_pc,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    output logic [DATA_W-1:0]         instr_data,
    output logic [ADDR_W-1:0]         instr_pc,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int unsigned        PTR_W   = $clog2(DEPTH);
    localparam int unsigned        CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0]  STEP_C  = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0] fetch_pc_r;
    logic              inflight_r;
    logic [ADDR_W-1:0] inflight_pc_r;
    logic [CNT_W-1:0]  count_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [DATA_W-1:0] data_mem_r [DEPTH];
    logic [ADDR_W-1:0] pc_mem_r   [DEPTH];

    logic [CNT_W-1:0]  credits_s;
    logic              head_valid_s;
    logic              issue_s;
    logic              push_s;
    logic              pop_s;

    assign head_valid_s = (count_r != {CNT_W{1'b0}});
    assign instr_valid  = head_valid_s && !redirect_valid;
    assign mem_addr     = fetch_pc_r;
    assign occupancy    = count_r;

    // Issue/push/pop decisions; a redirect suppresses all three.
    // Credits count the in-flight word so the FIFO always has room when it lands.
    always_comb begin
        credits_s = count_r + CNT_W'(inflight_r);
        issue_s   = 1'b0;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        if (redirect_valid) begin
            issue_s = 1'b0;
            push_s  = 1'b0;
            pop_s   = 1'b0;
        end else begin
            issue_s = fetch_en && (credits_s < DEPTH_C);
            push_s  = inflight_r;
            pop_s   = head_valid_s && instr_ready;
        end
    end

    // Head entry presented combinationally; forced to zero while the FIFO is empty.
    always_comb begin
        instr_data = {DATA_W{1'b0}};
        instr_pc   = {ADDR_W{1'b0}};
        if (head_valid_s) begin
            instr_data = data_mem_r[rd_ptr_r];
            instr_pc   = pc_mem_r[rd_ptr_r];
        end else begin
            instr_data = {DATA_W{1'b0}};
            instr_pc   = {ADDR_W{1'b0}};
        end
    end

    // PC, in-flight tracking, FIFO pointers and count.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            fetch_pc_r    <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= {ADDR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            wr_ptr_r      <= {PTR_W{1'b0}};
        end else if (redirect_valid) begin
            fetch_pc_r <= redirect_pc;
            inflight_r <= 1'b0;
            count_r    <= {CNT_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                inflight_pc_r <= fetch_pc_r;
                fetch_pc_r    <= fetch_pc_r + STEP_C;
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage: returned word paired with the PC it was fetched from.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_mem_r[i] <= {DATA_W{1'b0}};
                pc_mem_r[i]   <= {ADDR_W{1'b0}};
            end
        end else if (push_s) begin
            data_mem_r[wr_ptr_r] <= mem_q;
            pc_mem_r[wr_ptr_r]   <= inflight_pc_r;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios plus randomized traffic checked
// against an expected-PC-stream scoreboard and a functional RAM model.
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    logic        clk = 1'b0;
    logic        nreset;
    logic        fetch_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_q;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic [2:0]  occupancy;

    int          checks = 0;
    int          errors = 0;
    int          pops   = 0;
    logic [31:0] exp_pc;
    logic [31:0] salt   = 32'h0;
    logic        last_valid;

    instr_fetch_queue #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .PC_STEP(4)
    ) dut (
        .clk(clk), .nreset(nreset), .fetch_en(fetch_en), .mem_addr(mem_addr), .mem_q(mem_q),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // RAM contents: word index xor a per-test salt (salt 0 gives RAM[i] = i)
    function automatic logic [31:0] ram_fn(input logic [31:0] a);
        return (a >> 2) ^ salt;
    endfunction

    always @(posedge clk) mem_q <= ram_fn(mem_addr);

    task automatic apply_reset();
        nreset = 1'b0; fetch_en = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1 nreset = 1'b1;
        exp_pc = RESET_PC;
        pops = 0;
    endtask

    // One cycle of stimulus; every accepted instruction is scored against the expected stream
    task automatic drive_cycle(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc);
        fetch_en = fe; instr_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
        @(negedge clk);
        last_valid = instr_valid;
        checks++;
        if ($isunknown(occupancy) || occupancy > 3'(DEPTH)) begin
            errors++;
            $display("FAIL occupancy_range: got %0d, required 0..%0d", occupancy, DEPTH);
        end
        if (rv) begin
            checks++;
            if (instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL valid_in_redirect: got %b, required 0", instr_valid);
            end
            exp_pc = rpc;
        end else if (instr_valid === 1'b1 && rdy) begin
            checks++;
            if (instr_pc !== exp_pc || instr_data !== ram_fn(exp_pc)) begin
                errors++;
                $display("FAIL stream: got pc=%h data=%h, required pc=%h data=%h",
                         instr_pc, instr_data, exp_pc, ram_fn(exp_pc));
            end
            exp_pc = exp_pc + PC_STEP;
            pops++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nreset = 1'b0; fetch_en = 1'b1; instr_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || occupancy !== 3'd0 || mem_addr !== RESET_PC ||
            instr_data !== 32'h0 || instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: got v=%b occ=%0d addr=%h data=%h pc=%h, required 0 0 %h 0 0",
                     instr_valid, occupancy, mem_addr, instr_data, instr_pc, RESET_PC);
        end
    endtask

    task automatic test_stream();
        salt = 32'h0;
        apply_reset();
        for (int k = 0; k < 12; k++) begin
            fetch_en = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (mem_addr !== 32'(4 * k) || instr_valid !== (k >= 2)) begin
                errors++;
                $display("FAIL stream_timing k=%0d: got addr=%h v=%b, required addr=%h v=%b",
                         k, mem_addr, instr_valid, 32'(4 * k), (k >= 2));
            end
            if (k >= 2) begin
                checks++;
                if (instr_pc !== 32'(4 * (k - 2)) || instr_data !== 32'(k - 2) || occupancy !== 3'd1) begin
                    errors++;
                    $display("FAIL stream_head k=%0d: got pc=%h data=%h occ=%0d, required pc=%h data=%h occ=1",
                             k, instr_pc, instr_data, occupancy, 32'(4 * (k - 2)), 32'(k - 2));
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure();
        int run;
        int maxrun;
        salt = $urandom;
        apply_reset();
        repeat (10) drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checks++;
        if (occupancy !== 3'd4 || mem_addr !== 32'h10 || instr_valid !== 1'b1 ||
            instr_pc !== 32'h0 || instr_data !== ram_fn(32'h0)) begin
            errors++;
            $display("FAIL backpressure_hold: got occ=%0d addr=%h v=%b pc=%h, required occ=4 addr=10 v=1 pc=0",
                     occupancy, mem_addr, instr_valid, instr_pc);
        end
        @(posedge clk);
        #1;
        run = 0; maxrun = 0;
        for (int j = 0; j < 12; j++) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
            run = last_valid ? 0 : run + 1;
            if (run > maxrun) maxrun = run;
        end
        checks++;
        if (maxrun > 1 || pops < 11) begin
            errors++;
            $display("FAIL backpressure_resume: got gap=%0d pops=%0d, required gap<=1 pops>=11", maxrun, pops);
        end
    endtask

    task automatic test_redirect_flush();
        int first_j;
        salt = $urandom;
        apply_reset();
        repeat (4) drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        fetch_en = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        checks++;
        if (occupancy !== 3'd3 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_cycle: got occ=%0d v=%b, required occ=3 v=0", occupancy, instr_valid);
        end
        exp_pc = 32'h100;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (occupancy !== 3'd0 || instr_valid !== 1'b0 || mem_addr !== 32'h100) begin
            errors++;
            $display("FAIL redirect_flush: got occ=%0d v=%b addr=%h, required occ=0 v=0 addr=100",
                     occupancy, instr_valid, mem_addr);
        end
        @(posedge clk);
        #1;
        first_j = -1;
        for (int j = 0; j < 6; j++) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
            if (last_valid && first_j < 0) first_j = j;
        end
        checks++;
        if (first_j < 0 || first_j > 1 || pops < 4) begin
            errors++;
            $display("FAIL redirect_latency: got first=%0d pops=%0d, required first<=1 pops>=4", first_j, pops);
        end
    endtask

    task automatic test_redirect_drop();
        logic [31:0] tgt;
        salt = $urandom;
        tgt  = {$urandom_range(32'h3FFF_FFFF, 32'h100), 2'b00};
        apply_reset();
        repeat (6) drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        fetch_en = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = tgt;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || occupancy !== 3'd1) begin
            errors++;
            $display("FAIL drop_cycle: got v=%b occ=%0d, required v=0 occ=1", instr_valid, occupancy);
        end
        exp_pc = tgt;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        pops = 0;
        @(negedge clk);
        checks++;
        if (occupancy !== 3'd0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop_flush: got occ=%0d v=%b, required occ=0 v=0", occupancy, instr_valid);
        end
        @(posedge clk);
        #1;
        repeat (8) drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (pops < 6) begin
            errors++;
            $display("FAIL drop_resume: got pops=%0d, required >=6", pops);
        end
    endtask

    task automatic test_wrap();
        salt = $urandom;
        apply_reset();
        drive_cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        repeat (8) drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (pops < 5 || exp_pc !== 32'h0000_0000 + PC_STEP * (pops - 1)) begin
            errors++;
            $display("FAIL pc_wrap: got pops=%0d next=%h, required pops>=5 and wrap through 0", pops, exp_pc);
        end
    endtask

    task automatic test_async_reset();
        salt = $urandom;
        apply_reset();
        repeat (4) drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        #2;
        checks++;
        if (occupancy !== 3'd3) begin
            errors++;
            $display("FAIL async_pre: got occ=%0d, required 3", occupancy);
        end
        nreset = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || occupancy !== 3'd0 || mem_addr !== RESET_PC ||
            instr_data !== 32'h0 || instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got v=%b occ=%0d addr=%h data=%h pc=%h, required all reset values",
                     instr_valid, occupancy, mem_addr, instr_data, instr_pc);
        end
        @(posedge clk);
        #1 nreset = 1'b1;
        exp_pc = RESET_PC;
        pops = 0;
        repeat (6) drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (pops < 4) begin
            errors++;
            $display("FAIL async_restart: got pops=%0d, required >=4", pops);
        end
    endtask

    task automatic test_random();
        logic fe, rdy, rv;
        logic [31:0] rpc;
        salt = $urandom;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            fe  = ($urandom_range(3, 0) != 0);
            rdy = ($urandom_range(2, 0) != 0);
            rv  = ($urandom_range(15, 0) == 0);
            rpc = $urandom;
            if ($urandom_range(3, 0) != 0) rpc[1:0] = 2'b00;
            drive_cycle(fe, rdy, rv, rpc);
        end
        checks++;
        if (pops < 40) begin
            errors++;
            $display("FAIL random_progress: got pops=%0d, required >=40", pops);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_redirect_drop();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
